// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, sync, blank and colour bundle between pipeline stages
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered sync/blank levels, line/frame pulses and frame counter
module vga_timing_gen #(
    parameter int HOR_TOTAL      = 1056,
    parameter int HOR_PIXELS     = 800,
    parameter int HOR_SYNC_START = 840,
    parameter int HOR_SYNC_TIME  = 128,
    parameter int VER_TOTAL      = 628,
    parameter int VER_PIXELS     = 600,
    parameter int VER_SYNC_START = 601,
    parameter int VER_SYNC_TIME  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if.out          vga_out,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_cnt
);
    localparam int HW  = HOR_TOTAL > 1 ? $clog2(HOR_TOTAL) : 1;
    localparam int VW  = VER_TOTAL > 1 ? $clog2(VER_TOTAL) : 1;
    localparam int HSE = HOR_SYNC_START + HOR_SYNC_TIME;
    localparam int VSE = VER_SYNC_START + VER_SYNC_TIME;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_hs, r_vs, r_hb, r_vb, r_fs, r_ls;
    logic [15:0]   r_fc;
    logic          w_hwrap, w_fwrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_hs_nxt, w_vs_nxt, w_hb_nxt, w_vb_nxt;
    // Decode the next position so the flags land in the same register stage as the counters
    always_comb begin
        w_hwrap  = r_h == HW'(HOR_TOTAL - 1);
        w_fwrap  = w_hwrap && r_v == VW'(VER_TOTAL - 1);
        w_h_nxt  = w_hwrap ? '0 : r_h + 1'b1;
        w_v_nxt  = w_fwrap ? '0 : w_hwrap ? r_v + 1'b1 : r_v;
        w_hs_nxt = int'(w_h_nxt) >= HOR_SYNC_START && int'(w_h_nxt) < HSE;
        w_vs_nxt = int'(w_v_nxt) >= VER_SYNC_START && int'(w_v_nxt) < VSE;
        w_hb_nxt = int'(w_h_nxt) >= HOR_PIXELS;
        w_vb_nxt = int'(w_v_nxt) >= VER_PIXELS;
    end
    // Advance position and flags when enabled; pulses only follow an enabled wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h  <= '0;
            r_v  <= '0;
            r_hs <= 1'b0;
            r_vs <= 1'b0;
            r_hb <= 1'b0;
            r_vb <= 1'b0;
            r_ls <= 1'b0;
            r_fs <= 1'b0;
            r_fc <= '0;
        end else if (en) begin
            r_h  <= w_h_nxt;
            r_v  <= w_v_nxt;
            r_hs <= w_hs_nxt;
            r_vs <= w_vs_nxt;
            r_hb <= w_hb_nxt;
            r_vb <= w_vb_nxt;
            r_ls <= w_hwrap;
            r_fs <= w_fwrap;
            r_fc <= w_fwrap ? r_fc + 16'd1 : r_fc;
        end else begin
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end
    end
    assign vga_out.hcount = 11'(r_h);
    assign vga_out.vcount = 11'(r_v);
    assign vga_out.hsync  = r_hs;
    assign vga_out.vsync  = r_vs;
    assign vga_out.hblnk  = r_hb;
    assign vga_out.vblnk  = r_vb;
    assign vga_out.rgb    = 12'h000;
    assign line_start     = r_ls;
    assign frame_start    = r_fs;
    assign frame_cnt      = r_fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-enable checks of three generator instances against a position-index model
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b1, en_a = 1'b0, fs_a, ls_a;
    logic rst_b = 1'b1, en_b = 1'b0, fs_b, ls_b;
    logic rst_c = 1'b1, en_c = 1'b0, fs_c, ls_c;
    logic [15:0] fc_a, fc_b, fc_c;
    int checks = 0;
    int errors = 0;
    vga_if if_a ();
    vga_if if_b ();
    vga_if if_c ();
    vga_timing_gen dut_a (.clk(clk), .rst(rst_a), .en(en_a), .vga_out(if_a),
        .frame_start(fs_a), .line_start(ls_a), .frame_cnt(fc_a));
    vga_timing_gen #(.HOR_TOTAL(16), .HOR_PIXELS(10), .HOR_SYNC_START(11), .HOR_SYNC_TIME(3),
        .VER_TOTAL(12), .VER_PIXELS(8), .VER_SYNC_START(9), .VER_SYNC_TIME(2))
    dut_b (.clk(clk), .rst(rst_b), .en(en_b), .vga_out(if_b),
        .frame_start(fs_b), .line_start(ls_b), .frame_cnt(fc_b));
    vga_timing_gen #(.HOR_TOTAL(1), .HOR_PIXELS(1), .HOR_SYNC_START(1), .HOR_SYNC_TIME(1),
        .VER_TOTAL(1), .VER_PIXELS(1), .VER_SYNC_START(1), .VER_SYNC_TIME(1))
    dut_c (.clk(clk), .rst(rst_c), .en(en_c), .vga_out(if_c),
        .frame_start(fs_c), .line_start(ls_c), .frame_cnt(fc_c));
    // Expected outputs after p enabled edges since reset; moved = the latest edge was enabled
    function automatic logic [55:0] model(input int unsigned p, input bit moved,
        input int ht, input int hp, input int hss, input int hst,
        input int vt, input int vp, input int vss, input int vst);
        int unsigned h, l, v;
        logic ls, fs;
        h  = p % ht;
        l  = p / ht;
        v  = l % vt;
        ls = moved && h == 0;
        fs = ls && v == 0;
        return {16'(l / vt), fs, ls, 11'(v), 11'(h), h >= hss && h < hss + hst,
                v >= vss && v < vss + vst, h >= hp, v >= vp, 12'h000};
    endfunction
    function automatic logic [55:0] ma(input int unsigned p, input bit moved);
        return model(p, moved, 1056, 800, 840, 128, 628, 600, 601, 4);
    endfunction
    function automatic logic [55:0] mb(input int unsigned p, input bit moved);
        return model(p, moved, 16, 10, 11, 3, 12, 8, 9, 2);
    endfunction
    function automatic logic [55:0] mc(input int unsigned p, input bit moved);
        return model(p, moved, 1, 1, 1, 1, 1, 1, 1, 1);
    endfunction
    function automatic logic [55:0] act_a();
        return {fc_a, fs_a, ls_a, if_a.vcount, if_a.hcount, if_a.hsync, if_a.vsync, if_a.hblnk, if_a.vblnk, if_a.rgb};
    endfunction
    function automatic logic [55:0] act_b();
        return {fc_b, fs_b, ls_b, if_b.vcount, if_b.hcount, if_b.hsync, if_b.vsync, if_b.hblnk, if_b.vblnk, if_b.rgb};
    endfunction
    function automatic logic [55:0] act_c();
        return {fc_c, fs_c, ls_c, if_c.vcount, if_c.hcount, if_c.hsync, if_c.vsync, if_c.hblnk, if_c.vblnk, if_c.rgb};
    endfunction
    // One reset edge with enable held high on every instance; returns at a negedge with rst low
    task automatic do_reset();
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    endtask
    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 37; i++) begin
            en_a = 1'($urandom); en_b = 1'($urandom); en_c = 1'($urandom);
            @(negedge clk);
        end
        do_reset();
        checks++;
        if (act_a() !== ma(0, 0)) begin errors++; $display("FAIL reset_a got=%h exp=%h", act_a(), ma(0, 0)); end
        checks++;
        if (act_b() !== mb(0, 0)) begin errors++; $display("FAIL reset_b got=%h exp=%h", act_b(), mb(0, 0)); end
        checks++;
        if (act_c() !== mc(0, 0)) begin errors++; $display("FAIL reset_c got=%h exp=%h", act_c(), mc(0, 0)); end
    endtask
    task automatic test_line_wrap();
        int unsigned p = 0;
        int lsn = 0;
        do_reset();
        en_a = 1'b1;
        for (int i = 0; i < 1056; i++) begin
            @(negedge clk);
            p++;
            lsn += int'(ls_a);
            checks++;
            if (act_a() !== ma(p, 1)) begin errors++; $display("FAIL line_wrap p=%0d got=%h exp=%h", p, act_a(), ma(p, 1)); end
        end
        en_a = 1'b0;
        checks++;
        if (lsn != 1 || if_a.vcount !== 11'd1 || if_a.hcount !== 11'd0)
        begin errors++; $display("FAIL line_wrap_end ls_count=%0d v=%0d h=%0d exp 1,1,0", lsn, if_a.vcount, if_a.hcount); end
    endtask
    task automatic test_hsync_hblnk();
        int unsigned p = 0;
        int hsn = 0;
        do_reset();
        for (int i = 0; i < 2000 && p < 1000; i++) begin
            en_a = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (en_a) p++;
            if (en_a && if_a.vcount == 11'd0 && if_a.hsync === 1'b1) hsn++;
            checks++;
            if (act_a() !== ma(p, en_a)) begin errors++; $display("FAIL hsync_hblnk p=%0d got=%h exp=%h", p, act_a(), ma(p, en_a)); end
        end
        en_a = 1'b0;
        checks++;
        if (hsn != 128 || p < 1000) begin errors++; $display("FAIL hsync_width got=%0d exp=128 (p=%0d)", hsn, p); end
    endtask
    task automatic test_frame();
        int unsigned p = 0;
        int fsn = 0;
        do_reset();
        for (int i = 0; i < 1500 && p < 389; i++) begin
            en_b = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (en_b) p++;
            fsn += int'(fs_b);
            checks++;
            if (act_b() !== mb(p, en_b)) begin errors++; $display("FAIL frame p=%0d got=%h exp=%h", p, act_b(), mb(p, en_b)); end
        end
        en_b = 1'b0;
        checks++;
        if (fsn != 2 || fc_b !== 16'd2 || p < 389) begin errors++; $display("FAIL frame_count pulses=%0d cnt=%0d exp 2,2", fsn, fc_b); end
    endtask
    task automatic test_freeze();
        do_reset();
        en_b = 1'b1;
        repeat (53) @(negedge clk);
        en_b = 1'b0;
        checks++;
        if (if_b.hcount !== 11'd5 || if_b.vcount !== 11'd3) begin errors++; $display("FAIL freeze_pos h=%0d v=%0d exp 5,3", if_b.hcount, if_b.vcount); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (act_b() !== mb(53, 0)) begin errors++; $display("FAIL freeze_hold i=%0d got=%h exp=%h", i, act_b(), mb(53, 0)); end
        end
        en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        checks++;
        if (if_b.hcount !== 11'd6 || act_b() !== mb(54, 1)) begin errors++; $display("FAIL freeze_resume got=%h exp=%h", act_b(), mb(54, 1)); end
    endtask
    task automatic test_mid_reset();
        do_reset();
        en_b = 1'b1;
        repeat (156) @(negedge clk);
        checks++;
        if (if_b.hsync !== 1'b1 || if_b.vsync !== 1'b1 || act_b() !== mb(156, 1))
        begin errors++; $display("FAIL mid_reset_pre got=%h exp=%h", act_b(), mb(156, 1)); end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        checks++;
        if (act_b() !== mb(0, 0)) begin errors++; $display("FAIL mid_reset got=%h exp=%h", act_b(), mb(0, 0)); end
        @(negedge clk);
        en_b = 1'b0;
        checks++;
        if (act_b() !== mb(1, 1)) begin errors++; $display("FAIL mid_reset_after got=%h exp=%h", act_b(), mb(1, 1)); end
    endtask
    task automatic test_frame_cnt_wrap();
        int unsigned p = 0;
        do_reset();
        en_c = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            p++;
            checks++;
            if (act_c() !== mc(p, 1)) begin errors++; $display("FAIL cnt_run p=%0d got=%h exp=%h", p, act_c(), mc(p, 1)); end
        end
        checks++;
        if (fc_c !== 16'hFFFF) begin errors++; $display("FAIL cnt_preload got=%h exp=ffff", fc_c); end
        @(negedge clk);
        en_c = 1'b0;
        checks++;
        if (fc_c !== 16'h0000 || fs_c !== 1'b1) begin errors++; $display("FAIL cnt_wrap cnt=%h fs=%b exp 0000,1", fc_c, fs_c); end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_line_wrap();
        test_hsync_hblnk();
        test_frame();
        test_freeze();
        test_mid_reset();
        test_frame_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
